// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice reused per nibble, LSB nibble first.
// Optional macro CLA_SERIAL_SUB_EN adds a 'sub' input for A-B via inverted B and carry-in of 1.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               sub_sel;

    logic [3:0]         an;
    logic [3:0]         bn;
    logic [3:0]         p;
    logic [3:0]         g;
    logic               c1;
    logic               c2;
    logic               c3;
    logic               c4;

`ifdef CLA_SERIAL_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Every carry is expanded directly from p, g and the carry flop so no bit waits on its neighbour.
    always_comb begin
        an = a_reg[{cnt, 2'b00} +: 4];
        bn = b_reg[{cnt, 2'b00} +: 4];
        p  = an ^ bn;
        g  = an & bn;
        c1 = g[0] | (p[0] & carry);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub_sel}};
                        carry <= sub_sel | cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{cnt, 2'b00} +: 4] <= p ^ {c3, c2, c1, carry};
                    carry <= c4;
                    // The last nibble exits to DONE instead of advancing the counter past NIB-1.
                    if (cnt == CNT_W'(NIB - 1)) begin
                        cout  <= c4;
                        ovf   <= c3 ^ c4;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder (WIDTH=16): directed vectors, expected results queued
// at issue and popped by an independent monitor on each output handshake.
module tb_cla_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int               nVec;
    int               nErr;
    logic [31:0]      expQ[$];

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one operation, queue its result {sum,cout,ovf}, and check out_valid rises 4 edges later.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vc, input logic [WIDTH-1:0] esum,
                                 input logic ecout, input logic eovf);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        expQ.push_back(32'({esum, ecout, eovf}));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", 32'(n), 32'd4);
    endtask

`ifdef CLA_SERIAL_SUB_EN
    task automatic applySub(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic [WIDTH-1:0] esum, input logic ecout, input logic eovf);
        sub = 1'b1;
        applyStimulus(va, vb, 1'b0, esum, ecout, eovf);
        sub = 1'b0;
    endtask
`endif

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, want none", {sum, cout, ovf});
            end else begin
                checkOutput("result", 32'({sum, cout, ovf}), expQ.pop_front());
            end
        end
    end

    initial begin
        int  n;
        logic sawValid;
        nVec      = 0;
        nErr      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
`ifdef CLA_SERIAL_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout_ovf", 32'({cout, ovf}), 32'd0);

        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef CLA_SERIAL_SUB_EN
        applySub(16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        applySub(16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Backpressure: let the previous result drain, then stall the consumer.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);
        in_valid = 1'b1;
        a        = 16'h0001;
        b        = 16'h0002;
        cin      = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold", 32'({sum, cout, ovf}), 32'({16'h0000, 1'b1, 1'b0}));
        end
        expQ.push_back(32'({16'h0003, 1'b0, 1'b0}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("bp_second_latency", 32'(n), 32'd4);
        @(posedge clk); #1;

        // Reset two nibbles into an operation: it must vanish without an output handshake.
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h1111;
        cin      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_rst_sum", 32'(sum), 32'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        sawValid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midrun_rst_no_output", 32'(sawValid), 32'd0);

        applyStimulus(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);

        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
